// File: rtl/i2c_pkg.sv
// Shared I2C definitions: bit-controller command codes and byte-sequencer state encodings.
package i2c_pkg;

   localparam int unsigned CMD_W  = 4;
   localparam int unsigned BYTE_W = 8;
   localparam int unsigned CNT_W  = 3;
   localparam int unsigned WDOG_W = 16;

   localparam logic [CMD_W-1:0] I2C_CMD_NOP   = 4'b0000;
   localparam logic [CMD_W-1:0] I2C_CMD_START = 4'b0001;
   localparam logic [CMD_W-1:0] I2C_CMD_STOP  = 4'b0010;
   localparam logic [CMD_W-1:0] I2C_CMD_WRITE = 4'b0100;
   localparam logic [CMD_W-1:0] I2C_CMD_READ  = 4'b1000;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_START = 3'd1,
      ST_WRITE = 3'd2,
      ST_READ  = 3'd3,
      ST_ACK   = 3'd4,
      ST_STOP  = 3'd5
   } seq_state_e;

endpackage

// File: rtl/i2c_byte_sequencer_if.sv
// Host register-side and bit-controller-side signals of the I2C byte sequencer.
interface i2c_byte_sequencer_if;
   import i2c_pkg::*;

   logic                start;
   logic                stop;
   logic                read;
   logic                write;
   logic                ack_in;
   logic [BYTE_W-1:0]   din;
   logic                cmd_ack;
   logic                ack_out;
   logic [BYTE_W-1:0]   dout;
   logic                i2c_al;
   logic                timeout;
   logic [CMD_W-1:0]    core_cmd;
   logic                core_txd;
   logic                core_ack;
   logic                core_rxd;
   logic                core_al;

   modport slave (
      input  start, stop, read, write, ack_in, din,
      input  core_ack, core_rxd, core_al,
      output cmd_ack, ack_out, dout, i2c_al, timeout,
      output core_cmd, core_txd
   );

   modport master (
      output start, stop, read, write, ack_in, din,
      output core_ack, core_rxd, core_al,
      input  cmd_ack, ack_out, dout, i2c_al, timeout,
      input  core_cmd, core_txd
   );

endinterface

// File: rtl/i2c_ack_watchdog.sv
// Per-bit-command watchdog: reloads on each new command, counts down while waiting for core_ack.
module i2c_ack_watchdog
   import i2c_pkg::*;
#(
   parameter logic [WDOG_W-1:0] TIMEOUT_CYC = 16'd65535
) (
   input  logic clk,
   input  logic rst,
   input  logic load_i,
   input  logic run_i,
   output logic expire_c_o
);

   logic [WDOG_W-1:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (load_i) begin
         cnt_d = TIMEOUT_CYC;
      end else if (run_i && (cnt_q != '0)) begin
         cnt_d = cnt_q - WDOG_W'(1);
      end
   end

   // Expiry fires on the edge that would take the count to zero.
   assign expire_c_o = run_i && (cnt_q == WDOG_W'(1));

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

endmodule

// File: rtl/i2c_byte_sequencer.sv
// Turns one host byte request into START / 8 data bits / ACK / STOP bit commands.
// Optional core_ack watchdog enabled by defining I2C_BYTE_TIMEOUT_EN.
module i2c_byte_sequencer
   import i2c_pkg::*;
#(
   parameter logic [WDOG_W-1:0] TIMEOUT_CYC = 16'd65535
) (
   input  logic                 clk,
   input  logic                 rst,
   i2c_byte_sequencer_if.slave  bus
);

   seq_state_e        state_q, state_d;
   logic [BYTE_W-1:0] sr_q, sr_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic [CMD_W-1:0]  core_cmd_q, core_cmd_d;
   logic              core_txd_q, core_txd_d;
   logic              cmd_ack_q, cmd_ack_d;
   logic              ack_out_q, ack_out_d;
   logic              al_q, al_d;
   logic              tmo_q, tmo_d;
   logic              busy_c, load_c, expire_c, req_c;

   assign busy_c = (state_q != ST_IDLE);
   assign req_c  = (bus.start | bus.stop | bus.read | bus.write) & ~cmd_ack_q;

`ifdef I2C_BYTE_TIMEOUT_EN
   i2c_ack_watchdog #(.TIMEOUT_CYC(TIMEOUT_CYC)) u_wdog (
      .clk        (clk),
      .rst        (rst),
      .load_i     (load_c),
      .run_i      (busy_c & ~bus.core_ack),
      .expire_c_o (expire_c)
   );
`else
   logic unused_wdog_c;
   assign expire_c      = 1'b0;
   assign unused_wdog_c = ^{TIMEOUT_CYC, load_c};
`endif

   always_comb begin
      state_d    = state_q;
      sr_d       = sr_q;
      cnt_d      = cnt_q;
      core_cmd_d = core_cmd_q;
      core_txd_d = core_txd_q;
      cmd_ack_d  = 1'b0;
      ack_out_d  = ack_out_q;
      al_d       = 1'b0;
      tmo_d      = 1'b0;
      load_c     = 1'b0;

      // Arbitration loss beats a same-cycle ack; an ack beats watchdog expiry.
      if (busy_c && bus.core_al) begin
         state_d    = ST_IDLE;
         core_cmd_d = I2C_CMD_NOP;
         al_d       = 1'b1;
      end else if (busy_c && !bus.core_ack && expire_c) begin
         state_d    = ST_IDLE;
         core_cmd_d = I2C_CMD_NOP;
         tmo_d      = 1'b1;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (req_c) begin
                  sr_d   = bus.din;
                  cnt_d  = CNT_W'(7);
                  load_c = 1'b1;
                  if (bus.start) begin
                     state_d    = ST_START;
                     core_cmd_d = I2C_CMD_START;
                  end else if (bus.read) begin
                     state_d    = ST_READ;
                     core_cmd_d = I2C_CMD_READ;
                  end else if (bus.write) begin
                     state_d    = ST_WRITE;
                     core_cmd_d = I2C_CMD_WRITE;
                     core_txd_d = bus.din[7];
                  end else begin
                     state_d    = ST_STOP;
                     core_cmd_d = I2C_CMD_STOP;
                  end
               end
            end
            ST_START: begin
               if (bus.core_ack) begin
                  load_c = 1'b1;
                  if (bus.read) begin
                     state_d    = ST_READ;
                     core_cmd_d = I2C_CMD_READ;
                  end else if (bus.write) begin
                     state_d    = ST_WRITE;
                     core_cmd_d = I2C_CMD_WRITE;
                     core_txd_d = sr_q[7];
                  end else if (bus.stop) begin
                     state_d    = ST_STOP;
                     core_cmd_d = I2C_CMD_STOP;
                  end else begin
                     state_d    = ST_IDLE;
                     core_cmd_d = I2C_CMD_NOP;
                     cmd_ack_d  = 1'b1;
                  end
               end
            end
            ST_WRITE, ST_READ: begin
               if (bus.core_ack) begin
                  load_c = 1'b1;
                  sr_d   = {sr_q[6:0], bus.core_rxd};
                  cnt_d  = cnt_q - CNT_W'(1);
                  if (state_q == ST_WRITE) begin
                     core_txd_d = sr_q[6];
                  end
                  if (cnt_q == '0) begin
                     state_d = ST_ACK;
                     if (state_q == ST_READ) begin
                        core_cmd_d = I2C_CMD_WRITE;
                        core_txd_d = bus.ack_in;
                     end else begin
                        core_cmd_d = I2C_CMD_READ;
                     end
                  end
               end
            end
            ST_ACK: begin
               if (bus.core_ack) begin
                  load_c    = 1'b1;
                  ack_out_d = bus.core_rxd;
                  if (bus.stop) begin
                     state_d    = ST_STOP;
                     core_cmd_d = I2C_CMD_STOP;
                  end else begin
                     state_d    = ST_IDLE;
                     core_cmd_d = I2C_CMD_NOP;
                     cmd_ack_d  = 1'b1;
                  end
               end
            end
            ST_STOP: begin
               if (bus.core_ack) begin
                  state_d    = ST_IDLE;
                  core_cmd_d = I2C_CMD_NOP;
                  cmd_ack_d  = 1'b1;
               end
            end
            default: begin
               state_d    = ST_IDLE;
               core_cmd_d = I2C_CMD_NOP;
            end
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= ST_IDLE;
         sr_q       <= '0;
         cnt_q      <= '0;
         core_cmd_q <= I2C_CMD_NOP;
         core_txd_q <= 1'b0;
         cmd_ack_q  <= 1'b0;
         ack_out_q  <= 1'b0;
         al_q       <= 1'b0;
         tmo_q      <= 1'b0;
      end else begin
         state_q    <= state_d;
         sr_q       <= sr_d;
         cnt_q      <= cnt_d;
         core_cmd_q <= core_cmd_d;
         core_txd_q <= core_txd_d;
         cmd_ack_q  <= cmd_ack_d;
         ack_out_q  <= ack_out_d;
         al_q       <= al_d;
         tmo_q      <= tmo_d;
      end
   end

   assign bus.cmd_ack  = cmd_ack_q;
   assign bus.ack_out  = ack_out_q;
   assign bus.dout     = sr_q;
   assign bus.i2c_al   = al_q;
   assign bus.timeout  = tmo_q;
   assign bus.core_cmd = core_cmd_q;
   assign bus.core_txd = core_txd_q;

endmodule

// File: tb/tb_i2c_byte_sequencer.sv
// Self-checking bench for i2c_byte_sequencer: the bench plays both host and bit controller.
module tb_i2c_byte_sequencer;
   import i2c_pkg::*;

   typedef struct packed {
      logic [3:0] cmd;
      logic       chk;   // compare core_txd for this command
      logic       txd;
      logic [1:0] kind;  // 0 framing, 1 data bit, 2 ack bit
   } exp_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   n_vec = 0;
   int   n_bad = 0;
   logic [7:0] m_dout = 8'h00;
   logic       m_ack_out = 1'b0;

   i2c_byte_sequencer_if bus ();

   i2c_byte_sequencer #(.TIMEOUT_CYC(16'd10)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.slave)
   );

   always #5 clk = ~clk;

   initial begin
      #2ms;
      $display("FAIL sim_time_limit: got running expected finished");
      $fatal(1, "time limit");
   end

   task automatic check_eq(input string tag, input logic [15:0] got, input logic [15:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic exp_t mk(input logic [3:0] c, input logic k, input logic t, input logic [1:0] kd);
      exp_t e;
      e.cmd = c; e.chk = k; e.txd = t; e.kind = kd;
      return e;
   endfunction

   task automatic drop_req();
      bus.start = 1'b0; bus.stop = 1'b0; bus.read = 1'b0; bus.write = 1'b0;
   endtask

   task automatic check_reset_outputs(input string tag);
      check_eq({tag, "_cmd_ack"},  16'(bus.cmd_ack),  16'd0);
      check_eq({tag, "_ack_out"},  16'(bus.ack_out),  16'd0);
      check_eq({tag, "_dout"},     16'(bus.dout),     16'h00);
      check_eq({tag, "_i2c_al"},   16'(bus.i2c_al),   16'd0);
      check_eq({tag, "_timeout"},  16'(bus.timeout),  16'd0);
      check_eq({tag, "_core_cmd"}, 16'(bus.core_cmd), 16'(I2C_CMD_NOP));
      check_eq({tag, "_core_txd"}, 16'(bus.core_txd), 16'd0);
      check_eq({tag, "_state"},    16'(dut.state_q),  16'(ST_IDLE));
   endtask

   // One host request; rx[8:1] are the data bits returned MSB first, rx[0] the ACK-phase bit.
   task automatic run_xfer(input logic s, input logic p, input logic r, input logic w,
                           input logic ai, input logic [7:0] d, input logic [8:0] rx,
                           input int al_at, input logic al_ack, input int rst_at);
      exp_t q[$];
      logic rd, wr, rb;
      logic [7:0] sr;
      int dk;
      rd = r;
      wr = w & ~r;
      if (s) q.push_back(mk(I2C_CMD_START, 1'b0, 1'b0, 2'd0));
      for (int i = 0; i < 8; i++) begin
         if (rd)      q.push_back(mk(I2C_CMD_READ, 1'b0, 1'b0, 2'd1));
         else if (wr) q.push_back(mk(I2C_CMD_WRITE, 1'b1, d[7-i], 2'd1));
      end
      if (rd)      q.push_back(mk(I2C_CMD_WRITE, 1'b1, ai, 2'd2));
      else if (wr) q.push_back(mk(I2C_CMD_READ, 1'b0, 1'b0, 2'd2));
      if (p) q.push_back(mk(I2C_CMD_STOP, 1'b0, 1'b0, 2'd0));

      sr = d;
      dk = 0;
      bus.start = s; bus.stop = p; bus.read = r; bus.write = w;
      bus.ack_in = ai; bus.din = d;

      for (int i = 0; i < q.size(); i++) begin
         @(negedge clk);
         bus.core_ack = 1'b0;
         repeat ($urandom_range(0, 2)) @(negedge clk);
         check_eq("core_cmd", 16'(bus.core_cmd), 16'(q[i].cmd));
         if (q[i].chk) check_eq("core_txd", 16'(bus.core_txd), 16'(q[i].txd));
         check_eq("cmd_ack_busy", 16'(bus.cmd_ack), 16'd0);

         if (i == rst_at) begin
            rst = 1'b1;
            drop_req();
            @(negedge clk);
            check_reset_outputs("mid_rst");
            rst = 1'b0;
            m_dout = 8'h00;
            m_ack_out = 1'b0;
            return;
         end

         if (q[i].kind == 2'd1)      rb = rx[8-dk];
         else if (q[i].kind == 2'd2) rb = rx[0];
         else                        rb = 1'($urandom_range(0, 1));

         if (i == al_at) begin
            bus.core_al  = 1'b1;
            bus.core_ack = al_ack;
            bus.core_rxd = rb;
            @(negedge clk);
            bus.core_al  = 1'b0;
            bus.core_ack = 1'b0;
            m_dout = sr;
            check_eq("al_pulse",    16'(bus.i2c_al),   16'd1);
            check_eq("al_core_cmd", 16'(bus.core_cmd), 16'(I2C_CMD_NOP));
            check_eq("al_cmd_ack",  16'(bus.cmd_ack),  16'd0);
            check_eq("al_state",    16'(dut.state_q),  16'(ST_IDLE));
            check_eq("al_dout",     16'(bus.dout),     16'(m_dout));
            check_eq("al_ack_out",  16'(bus.ack_out),  16'(m_ack_out));
            drop_req();
            @(negedge clk);
            check_eq("al_one_shot", 16'(bus.i2c_al),   16'd0);
            check_eq("al_idle_cmd", 16'(bus.core_cmd), 16'(I2C_CMD_NOP));
            check_eq("al_no_ack",   16'(bus.cmd_ack),  16'd0);
            return;
         end

         bus.core_ack = 1'b1;
         bus.core_rxd = rb;
         if (q[i].kind == 2'd1) begin
            sr = {sr[6:0], rb};
            dk++;
         end
         if (q[i].kind == 2'd2) m_ack_out = rb;
      end

      @(negedge clk);
      bus.core_ack = 1'b0;
      m_dout = (rd | wr) ? rx[8:1] : d;
      check_eq("done_cmd_ack",  16'(bus.cmd_ack),  16'd1);
      check_eq("done_core_cmd", 16'(bus.core_cmd), 16'(I2C_CMD_NOP));
      check_eq("done_dout",     16'(bus.dout),     16'(m_dout));
      check_eq("done_ack_out",  16'(bus.ack_out),  16'(m_ack_out));
      check_eq("done_i2c_al",   16'(bus.i2c_al),   16'd0);
      check_eq("done_timeout",  16'(bus.timeout),  16'd0);
      drop_req();
      @(negedge clk);
      check_eq("cmd_ack_pulse", 16'(bus.cmd_ack),  16'd0);
      check_eq("dout_held",     16'(bus.dout),     16'(m_dout));
   endtask

   initial begin
      logic s, p, r, w, ai;
      logic [7:0] d;
      logic [8:0] rx;
      int al_at;

      drop_req();
      bus.ack_in = 1'b0; bus.din = 8'h00;
      bus.core_ack = 1'b0; bus.core_rxd = 1'b0; bus.core_al = 1'b0;
      rst = 1'b1;
      repeat (3) @(negedge clk);
      check_reset_outputs("reset");
      rst = 1'b0;
      @(negedge clk);

      // write with START/STOP, slave ACKs
      run_xfer(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 8'hA5, {8'h3C, 1'b0}, -1, 1'b0, -1);
      // read with NACK
      run_xfer(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 8'h00, {8'hC3, 1'b0}, -1, 1'b0, -1);
      // read and write both requested: read only
      run_xfer(1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 8'h5A, {8'h96, 1'b1}, -1, 1'b0, -1);
      // arbitration lost on 3rd data bit
      run_xfer(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 8'hF0, {8'hAA, 1'b0}, 3, 1'b0, -1);
      // arbitration lost together with core_ack
      run_xfer(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 8'h81, {8'h55, 1'b0}, 4, 1'b1, -1);
      // slave NACK sets ack_out, then reset mid-read clears everything
      run_xfer(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'h77, {8'h0F, 1'b1}, -1, 1'b0, -1);
      run_xfer(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'h12, {8'hFF, 1'b0}, -1, 1'b0, 4);
      // START-only and STOP-only requests
      run_xfer(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h3E, 9'h000, -1, 1'b0, -1);
      run_xfer(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'hE3, 9'h000, -1, 1'b0, -1);

      for (int t = 0; t < 40; t++) begin
         s  = 1'($urandom_range(0, 1));
         p  = 1'($urandom_range(0, 1));
         r  = 1'($urandom_range(0, 1));
         w  = 1'($urandom_range(0, 1));
         ai = 1'($urandom_range(0, 1));
         if (!(s | p | r | w)) w = 1'b1;
         d  = 8'($urandom);
         rx = 9'($urandom);
         al_at = ($urandom_range(0, 5) == 0) ? int'($urandom_range(0, 10)) : -1;
         run_xfer(s, p, r, w, ai, d, rx, al_at, 1'($urandom_range(0, 1)), -1);
      end

      // START issued, core_ack withheld
      bus.din = 8'h6B;
      bus.start = 1'b1;
`ifdef I2C_BYTE_TIMEOUT_EN
      repeat (10) @(negedge clk);
      check_eq("tmo_cmd_before",   16'(bus.core_cmd), 16'(I2C_CMD_START));
      check_eq("tmo_not_yet",      16'(bus.timeout),  16'd0);
      @(negedge clk);
      check_eq("tmo_pulse",        16'(bus.timeout),  16'd1);
      check_eq("tmo_core_cmd",     16'(bus.core_cmd), 16'(I2C_CMD_NOP));
      check_eq("tmo_no_cmd_ack",   16'(bus.cmd_ack),  16'd0);
      drop_req();
      @(negedge clk);
      check_eq("tmo_one_shot",     16'(bus.timeout),  16'd0);
      check_eq("tmo_no_cmd_ack2",  16'(bus.cmd_ack),  16'd0);
`else
      repeat (20) @(negedge clk);
      check_eq("notmo_timeout",    16'(bus.timeout),  16'd0);
      check_eq("notmo_cmd_hold",   16'(bus.core_cmd), 16'(I2C_CMD_START));
      bus.core_ack = 1'b1;
      @(negedge clk);
      bus.core_ack = 1'b0;
      check_eq("notmo_cmd_ack",    16'(bus.cmd_ack),  16'd1);
      check_eq("notmo_dout",       16'(bus.dout),     16'h6B);
      drop_req();
      @(negedge clk);
      check_eq("notmo_ack_pulse",  16'(bus.cmd_ack),  16'd0);
`endif

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule

// File: doc/i2c_byte_sequencer.md
# i2c_byte_sequencer

Byte-level sequencer sitting directly upstream of the I2C bit controller. It turns one host request into the matching sequence of bit commands: optional START, 8 data bits, the ACK bit, and optional STOP. It shifts data out and in, captures the received ACK, and aborts cleanly on arbitration loss. The host side is a register block; the core side drives the bit controller's cmd/din and consumes its cmd_ack/dout/al.

## Interface
- TIMEOUT_CYC, 65535: maximum cycles to wait for core_ack per bit command; used only with I2C_BYTE_TIMEOUT_EN; 16-bit, must be ≥1.
- clk  in  1  system clock; one clock domain.
- rst  in  1  reset, synchronous, active-high.
- start  in  1  generate START before the byte.
- stop  in  1  generate STOP after the byte or ACK.
- read  in  1  read one byte.
- write  in  1  write one byte.
- ack_in  in  1  ACK bit to send after a read (0 = ACK, 1 = NACK).
- din  in  8  byte to transmit, MSB first.
- cmd_ack  out  1  one-cycle pulse when the request completes.
- ack_out  out  1  ACK bit received after a write (0 = slave ACKed).
- dout  out  8  received byte.
- i2c_al  out  1  one-cycle pulse on arbitration loss.
- timeout  out  1  one-cycle pulse on core-ack watchdog expiry; tied 0 without the macro.
- core_cmd  out  4  bit command: NOP 0000, START 0001, STOP 0010, WRITE 0100, READ 1000.
- core_txd  out  1  bit value for a WRITE bit command.
- core_ack  in  1  bit controller done pulse, one cycle.
- core_rxd  in  1  bit sampled by the bit controller.
- core_al  in  1  arbitration lost from the bit controller.

## Operation
- Reset values: state ST_IDLE, cmd_ack 0, ack_out 0, dout 8'h00, i2c_al 0, timeout 0, core_cmd NOP, core_txd 0, bit counter 0.
- States: ST_IDLE, ST_START, ST_WRITE, ST_READ, ST_ACK, ST_STOP.
- ST_IDLE accepts a request when (start|stop|read|write) & ~cmd_ack.
  - Priority on accept: start → ST_START; else read → ST_READ; else write → ST_WRITE; else stop → ST_STOP.
  - On accept: load shift register with din and the bit counter with 7. core_cmd gets the state's command. In ST_WRITE, core_txd = din[7].
- ST_START on core_ack: read → ST_READ; else write → ST_WRITE (core_txd = sr[7]); else stop → ST_STOP; else ST_IDLE with cmd_ack.
- ST_WRITE/ST_READ on core_ack:
  - Update: sr <= {sr[6:0], core_rxd}, counter decrements. In ST_WRITE, core_txd <= next MSB (sr[6]).
  - When the counter is 0, go to ST_ACK. After a read: core_cmd WRITE, core_txd = ack_in. After a write: core_cmd READ.
- ST_ACK on core_ack: ack_out <= core_rxd. Then stop → ST_STOP, else ST_IDLE with cmd_ack.
- ST_STOP on core_ack: ST_IDLE with cmd_ack.
- dout = sr; valid in the cmd_ack cycle and held until the next accepted request.
- read and write both set: read wins, write is ignored.
- core_cmd and core_txd stay stable until core_ack. The host must hold its request bits until cmd_ack and drop them the cycle after.

## Timing
- Request sampled at edge N → core_cmd valid after edge N.
- core_ack at edge M → next core_cmd, or cmd_ack, valid after edge M; no extra bubble.
- Full write with START and STOP: 11 core_ack handshakes, then cmd_ack.
- core_al: next edge goes to ST_IDLE, core_cmd NOP, i2c_al pulses one cycle, cmd_ack not asserted, dout/ack_out unchanged.
- core_al and core_ack in the same cycle: core_al wins.
- rst mid-operation: all reset values at the next edge; core_cmd NOP.

## Configuration
- I2C_BYTE_TIMEOUT_EN defined: a 16-bit watchdog loads TIMEOUT_CYC on every new core_cmd and decrements while in a non-idle state without core_ack.
  - At 0: go to ST_IDLE, core_cmd NOP, timeout pulses one cycle, no cmd_ack.
  - core_ack in the expiry cycle wins.
  - core_al wins over timeout.
- Undefined: no watchdog logic; timeout tied 0; TIMEOUT_CYC unused.

## Structure
- Shared package i2c_pkg holds the I2C_CMD_NOP/START/STOP/WRITE/READ 4-bit constants (shared with the bit controller) and the byte-sequencer state encodings.
- One natural sub-module: i2c_ack_watchdog (load/decrement/expire counter), instantiated only under I2C_BYTE_TIMEOUT_EN.

## Test plan
- Write path: start=1, write=1, stop=1, din=8'hA5; bench acks each command, returns core_rxd=0 on the ACK bit.
  - Required: core_cmd sequence START, WRITE×8 with core_txd 1,0,1,0,0,1,0,1, READ, STOP.
  - Then cmd_ack pulses once and ack_out=0.
- Read path: read=1, ack_in=1, bench core_rxd bits 1,1,0,0,0,0,1,1.
  - Required: READ×8, then WRITE with core_txd=1, then cmd_ack, dout=8'hC3.
- Arbitration loss: core_al asserted during the 3rd WRITE bit.
  - Required: i2c_al pulses once, core_cmd=NOP next cycle, no cmd_ack, state ST_IDLE.
- Simultaneous events:
  - core_al together with core_ack → abort, no advance.
  - read=write=1 → READ sequence only.
  - rst mid-read → all outputs at reset values next cycle.
- Timeout with the macro, TIMEOUT_CYC=10: START issued, core_ack never returned.
  - Required: timeout pulses at cycle 10 after core_cmd, core_cmd=NOP, no cmd_ack.
  - Without the macro: timeout stays 0 and core_cmd holds START.
